// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard host receiver.
//   PS2_PREFIX_EXT / PS2_PREFIX_BREAK : scancode prefix bytes
//   PS2_FRAME_BITS                    : start + 8 data + parity + stop
//   ps2_frame_state_e                 : frame deserialiser states
package ps2_pkg;

  localparam logic [7:0]  PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0]  PS2_PREFIX_BREAK = 8'hF0;
  localparam int unsigned PS2_FRAME_BITS   = 11;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_frame_state_e;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises and glitch-filters ps2_clk/ps2_data, deframes
// 11-bit frames and checks start, odd parity, stop and inter-edge timeout.
//   clk, reset_n        : system clock, async active-low reset
//   ps2_clk, ps2_data   : asynchronous PS/2 lines
//   rx_byte             : last correctly received byte
//   rx_strobe           : one-cycle pulse, rx_byte valid
//   rx_err              : one-cycle pulse on start/parity/stop/timeout error
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       rx_err
);

  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]       clk_sync_q, data_sync_q;
  logic             filt_q, filt_d;
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
  logic             sample_q, sample_d;
  logic             bit_q;

  ps2_frame_state_e state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic [7:0]       byte_q, byte_d;
  logic             strobe_q, strobe_d;
  logic             err_q, err_d;

  // Filtered clock only moves after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    sample_d   = 1'b0;
    if (clk_sync_q[1] != filt_q) begin
      if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
        filt_d   = clk_sync_q[1];
        sample_d = ~clk_sync_q[1];
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    par_d    = par_q;
    byte_d   = byte_q;
    strobe_d = 1'b0;
    err_d    = 1'b0;
    tmo_d    = (state_q == StIdle || sample_q) ? '0 : tmo_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (sample_q) begin
          if (!bit_q) begin
            state_d = StData;
            idx_d   = '0;
            par_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StData: begin
        if (sample_q) begin
          shift_d = {bit_q, shift_q[7:1]};
          par_d   = par_q ^ bit_q;
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (sample_q) begin
          par_d   = par_q ^ bit_q;
          state_d = StStop;
        end
      end
      StStop: begin
        if (sample_q) begin
          // par_q holds the XOR of data and parity: 1 means odd total.
          if (bit_q && par_q) begin
            strobe_d = 1'b1;
            byte_d   = shift_q;
          end else begin
            err_d = 1'b1;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A timeout can only fire without a sample, so it never collides with a strobe.
    if (state_q != StIdle && !sample_q && tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
      err_d   = 1'b1;
      state_d = StIdle;
      tmo_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      sample_q    <= 1'b0;
      bit_q       <= 1'b1;
      state_q     <= StIdle;
      idx_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      byte_q      <= '0;
      strobe_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
      sample_q    <= sample_d;
      if (sample_d) bit_q <= data_sync_q[1];
      state_q     <= state_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      byte_q      <= byte_d;
      strobe_q    <= strobe_d;
      err_q       <= err_d;
    end
  end

  assign rx_byte   = byte_q;
  assign rx_strobe = strobe_q;
  assign rx_err    = err_q;

endmodule

// File: rtl/ps2_kbd_host_rx.sv
// PS/2 keyboard host receiver: frame receiver plus error counter and
// make/break/E0 scancode decoder.
//   clk, reset_n                 : system clock, async active-low reset
//   ps2_clk, ps2_data            : PS/2 lines from the bridge
//   rx_byte, rx_strobe, rx_err   : raw byte stream and error pulses
//   err_count                    : saturating count of rx_err pulses
//   key_code, key_extended,
//   key_released, key_strobe     : decoded key event, held until next strobe
module ps2_kbd_host_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       rx_err,
  output logic [7:0] err_count,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_released,
  output logic       key_strobe
);

  logic [7:0] err_cnt_q, err_cnt_d;
  logic       ext_q, ext_d;
  logic       rel_q, rel_d;
  logic [7:0] code_q, code_d;
  logic       key_ext_q, key_ext_d;
  logic       key_rel_q, key_rel_d;
  logic       key_stb_q, key_stb_d;

  ps2_rx_frame #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .rx_strobe (rx_strobe),
    .rx_err    (rx_err)
  );

  always_comb begin
    err_cnt_d = err_cnt_q;
    ext_d     = ext_q;
    rel_d     = rel_q;
    code_d    = code_q;
    key_ext_d = key_ext_q;
    key_rel_d = key_rel_q;
    key_stb_d = 1'b0;

    if (rx_err) begin
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      ext_d = 1'b0;
      rel_d = 1'b0;
    end else if (rx_strobe) begin
      if (rx_byte == PS2_PREFIX_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == PS2_PREFIX_BREAK) begin
        rel_d = 1'b1;
      end else begin
        key_stb_d = 1'b1;
        code_d    = rx_byte;
        key_ext_d = ext_q;
        key_rel_d = rel_q;
        ext_d     = 1'b0;
        rel_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= '0;
      ext_q     <= 1'b0;
      rel_q     <= 1'b0;
      code_q    <= '0;
      key_ext_q <= 1'b0;
      key_rel_q <= 1'b0;
      key_stb_q <= 1'b0;
    end else begin
      err_cnt_q <= err_cnt_d;
      ext_q     <= ext_d;
      rel_q     <= rel_d;
      code_q    <= code_d;
      key_ext_q <= key_ext_d;
      key_rel_q <= key_rel_d;
      key_stb_q <= key_stb_d;
    end
  end

  assign err_count    = err_cnt_q;
  assign key_code     = code_q;
  assign key_extended = key_ext_q;
  assign key_released = key_rel_q;
  assign key_strobe   = key_stb_q;

endmodule

// File: doc/ps2_kbd_host_rx.md
Name: ps2_kbd_host_rx

Overview:
Core-side receiver for the emulated PS/2 keyboard stream that the IO-controller bridge drives on its ps2_kbd_clk/ps2_kbd_data outputs. It synchronises and filters both lines, deframes 11-bit PS/2 frames and checks odd parity and stop bit. Valid bytes are then decoded into make/break key events with E0 extension tracking. It sits between the bridge and any core logic that consumes keyboard input (menus, keyboard-mapped controllers).

Parameters:
FILTER_LEN, 4, consecutive identical samples required before a filtered ps2_clk level changes (glitch filter).
TIMEOUT_CYCLES, 20000, clk cycles without a falling ps2_clk edge mid-frame before the frame is aborted.

Ports:
clk  input  1  core system clock; all logic is in this domain.
reset_n  input  1  asynchronous, active-low reset.
ps2_clk  input  1  PS/2 clock from the bridge; idles high; asynchronous to clk.
ps2_data  input  1  PS/2 data from the bridge; asynchronous to clk.
rx_byte  output  8  last correctly received byte.
rx_strobe  output  1  one-cycle pulse; rx_byte is valid in the same cycle.
rx_err  output  1  one-cycle pulse on parity, start, stop or timeout error.
err_count  output  8  saturating count of rx_err pulses.
key_code  output  8  scancode of the decoded event (prefix bytes excluded).
key_extended  output  1  the event was preceded by E0.
key_released  output  1  the event was preceded by F0 (break).
key_strobe  output  1  one-cycle pulse; key_* outputs are valid in the same cycle.

Behaviour:
- Reset: all outputs 0, frame FSM to IDLE, filtered clk = 1, prefix flags cleared, err_count = 0. Reset asserted mid-frame discards the partial frame.
- Input path:
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - Filtered clk changes only after FILTER_LEN consecutive equal synchronised samples.
  - A falling edge of the filtered clk produces a one-cycle sample pulse; synchronised data is captured on that pulse.
- Frame FSM, states IDLE, DATA, PARITY, STOP:
  - IDLE: on sample with data=0, go to DATA with bit index 0 and parity accumulator 0. On sample with data=1 (bad start), pulse rx_err and stay in IDLE.
  - DATA: shift bits in LSB first; after bit 7, go to PARITY.
  - PARITY: capture the parity bit; go to STOP.
  - STOP: require stop=1 and an odd total of ones across the 8 data bits plus parity. If both hold, pulse rx_strobe with rx_byte. Otherwise pulse rx_err. Return to IDLE in either case.
  - Timeout: a counter resets on each sample pulse and runs in every state except IDLE. Reaching TIMEOUT_CYCLES pulses rx_err and forces IDLE.
- rx_strobe and rx_err are asserted one cycle after the sample pulse of the stop bit. Total latency from the falling ps2_clk pin edge to rx_strobe is 2 + FILTER_LEN + 1 clk cycles.
- rx_strobe and rx_err are never high in the same cycle.
- err_count increments on each rx_err pulse and saturates at 255.
- Key decoder, driven by rx_strobe:
  - Byte E0: set ext; no key event.
  - Byte F0: set rel; no key event.
  - Any other byte: one cycle later, pulse key_strobe with key_code = byte, key_extended = ext, key_released = rel; then clear ext and rel.
  - rx_err clears ext and rel.
- key_* outputs hold their values until the next key_strobe.

Decomposition:
- Shared package ps2_pkg:
  - PS2_PREFIX_EXT = 8'hE0, PS2_PREFIX_BREAK = 8'hF0.
  - Frame-state enum (IDLE, DATA, PARITY, STOP).
  - PS2_FRAME_BITS = 11.
- Natural sub-module ps2_rx_frame: synchroniser, filter, frame FSM and timeout; outputs rx_byte, rx_strobe and rx_err. The top level adds err_count and the key decoder.

Test Plan:
- Frame 0x1C (data ones = 3, parity = 0), stop = 1 -> one rx_strobe with rx_byte = 0x1C; key_strobe with key_code = 0x1C, key_extended = 0, key_released = 0.
- Frames F0, 1C -> one rx_strobe per byte; a single key_strobe with key_code = 0x1C, key_released = 1, key_extended = 0.
- Frames E0, F0, 75 -> a single key_strobe with key_code = 0x75, key_extended = 1, key_released = 1; a following 0x75 yields key_extended = 0, key_released = 0.
- Frame 0x1C with parity bit flipped to 1 -> rx_err pulse, no rx_strobe, err_count = 1; a following good 0x29 gives rx_byte = 0x29.
- Stop 4 bits into a frame for more than TIMEOUT_CYCLES -> rx_err and FSM in IDLE; the next good frame 0x5A is received correctly.
- 1-cycle low glitches on ps2_clk during idle -> no sample pulse, no strobe or error. reset_n pulsed mid-frame -> all outputs 0 and err_count = 0; the next full frame is received correctly.
